// File: rtl/jpeg_cone_pkg.sv
// Shared types and constants for the jpeg cone arbiter slice.
package jpeg_cone_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int EVAL_CYC_MIN = 1;
   localparam int EVAL_CYC_MAX = 15;
   localparam int EVAL_CNT_W   = 4;
   localparam int SERVED_W     = 16;

   // Index width for NREQ requesters, never narrower than one bit
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jpeg_cone_arbiter_if.sv
// Request, cone and response signals shared between the arbiter and its users.
interface jpeg_cone_arbiter_if
   import jpeg_cone_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IN_W = 46
);
   localparam int ID_W = ptr_w(NREQ);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*IN_W-1:0] req_data;
   logic [NREQ-1:0]      req_ready;
   logic [IN_W-1:0]      cone_in;
   logic                 cone_out;
   logic                 rsp_valid;
   logic [ID_W-1:0]      rsp_id;
   logic                 rsp_bit;
   logic                 rsp_ready;
   logic [SERVED_W-1:0]  served_cnt;

   modport master (
      output req_valid, req_data, cone_out, rsp_ready,
      input  req_ready, cone_in, rsp_valid, rsp_id, rsp_bit, served_cnt
   );

   modport slave (
      input  req_valid, req_data, cone_out, rsp_ready,
      output req_ready, cone_in, rsp_valid, rsp_id, rsp_bit, served_cnt
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: the search starts at ptr and wraps around.
module rr_arbiter
   import jpeg_cone_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int PTR_W = ptr_w(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [NREQ-1:0]  grant
);

   logic [NREQ-1:0] req_rot;
   logic [NREQ-1:0] grant_rot;

   // Rotate so ptr sits at bit 0, keep the lowest request, rotate back
   always_comb begin
      req_rot   = NREQ'({req, req} >> ptr);
      grant_rot = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            grant_rot    = '0;
            grant_rot[k] = 1'b1;
         end
      end
      grant = NREQ'(({grant_rot, grant_rot} << ptr) >> NREQ);
   end

endmodule

// File: rtl/jpeg_cone_arbiter.sv
// Shares one multicycle jpeg timing cone between NREQ requesters.
module jpeg_cone_arbiter
   import jpeg_cone_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int IN_W     = 46,
   parameter int EVAL_CYC = 2
) (
   input logic                clk,
   input logic                rst_n,
   jpeg_cone_arbiter_if.slave bus
);

   localparam int ID_W = ptr_w(NREQ);

   if (EVAL_CYC < EVAL_CYC_MIN || EVAL_CYC > EVAL_CYC_MAX) begin : g_bad_eval_cyc
      $error("jpeg_cone_arbiter: EVAL_CYC must lie within 1..15");
   end

   arb_state_t            state;
   arb_state_t            state_nxt;
   logic [ID_W-1:0]       rr_ptr;
   logic [ID_W-1:0]       grant_idx;
   logic [ID_W-1:0]       rsp_id_q;
   logic [EVAL_CNT_W-1:0] eval_cnt;
   logic [IN_W-1:0]       cone_in_q;
   logic [IN_W-1:0]       sel_data;
   logic                  rsp_bit_q;
   logic [SERVED_W-1:0]   served_cnt_q;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       req_ready_c;
   logic                  handshake;
   logic                  eval_last;
   logic                  rsp_hs;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   // Grants are offered only in IDLE and never while reset is held
   assign req_ready_c = (state == IDLE && rst_n) ? grant : '0;
   assign handshake   = |(bus.req_valid & req_ready_c);
   assign eval_last   = (state == EVAL) && (eval_cnt == EVAL_CNT_W'(EVAL_CYC - 1));
   assign rsp_hs      = (state == RESP) && bus.rsp_ready;

   // Turn the one-hot grant into an index and pick that requester's vector
   always_comb begin
      grant_idx = '0;
      sel_data  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_idx = ID_W'(i);
            sel_data  = bus.req_data[i*IN_W +: IN_W];
         end
      end
   end

   // Next-state logic: accept, wait out the cone window, hold the response
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (handshake) state_nxt = EVAL;
         EVAL:    if (eval_last) state_nxt = RESP;
         RESP:    if (rsp_hs)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath: latch the winner, count the window, capture and count results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr       <= '0;
         cone_in_q    <= '0;
         rsp_id_q     <= '0;
         rsp_bit_q    <= 1'b0;
         eval_cnt     <= '0;
         served_cnt_q <= '0;
      end else begin
         if (handshake) begin
            cone_in_q <= sel_data;
            rsp_id_q  <= grant_idx;
            rr_ptr    <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            eval_cnt  <= '0;
         end else if (state == EVAL) begin
            eval_cnt  <= eval_cnt + 1'b1;
         end
         if (eval_last) begin
            rsp_bit_q <= bus.cone_out;
         end
         if (rsp_hs && served_cnt_q != '1) begin
            served_cnt_q <= served_cnt_q + 1'b1;
         end
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.cone_in    = cone_in_q;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_bit    = rsp_bit_q;
   assign bus.served_cnt = served_cnt_q;

endmodule

// File: tb/tb_jpeg_cone_arbiter.sv
// Self-checking bench for jpeg_cone_arbiter with a parity cone model and a response scoreboard.
module tb_jpeg_cone_arbiter;

   localparam int NREQ     = 4;
   localparam int IN_W     = 46;
   localparam int EVAL_CYC = 2;
   localparam int DW       = NREQ * IN_W;

   typedef struct {
      int   id;
      logic bit_v;
   } exp_t;

   typedef struct {
      logic [3:0]    valid;
      logic [DW-1:0] data;
      int            exp_id;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic cone_ovr_en;
   logic cone_ovr_val;

   int        n_checks = 0;
   int        n_fail   = 0;
   int        model_ptr;
   logic [15:0] model_served;
   exp_t      sb_q[$];
   exp_t      mon_e;
   vec_t      vecs[8];

   logic [3:0] sw_valid [2];
   logic       sw_cone  [2];
   logic       sw_ready [2];
   logic [3:0] sw_rr    [2];
   logic       sw_rv    [2];
   logic       sw_rb    [2];
   logic [1:0] sw_rid   [2];

   always #5 clk = ~clk;

   jpeg_cone_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W)) bus ();
   jpeg_cone_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W)) bus1 ();
   jpeg_cone_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W)) bus15 ();

   jpeg_cone_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .EVAL_CYC(EVAL_CYC)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   jpeg_cone_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .EVAL_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1)
   );
   jpeg_cone_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .EVAL_CYC(15)) dut15 (
      .clk(clk), .rst_n(rst_n), .bus(bus15)
   );

   // Cone model is parity of cone_in unless the bench overrides it
   assign bus.cone_out = cone_ovr_en ? cone_ovr_val : ^bus.cone_in;

   assign bus1.req_valid  = sw_valid[0];
   assign bus1.req_data   = '0;
   assign bus1.cone_out   = sw_cone[0];
   assign bus1.rsp_ready  = sw_ready[0];
   assign sw_rr[0]        = bus1.req_ready;
   assign sw_rv[0]        = bus1.rsp_valid;
   assign sw_rb[0]        = bus1.rsp_bit;
   assign sw_rid[0]       = bus1.rsp_id;

   assign bus15.req_valid = sw_valid[1];
   assign bus15.req_data  = '0;
   assign bus15.cone_out  = sw_cone[1];
   assign bus15.rsp_ready = sw_ready[1];
   assign sw_rr[1]        = bus15.req_ready;
   assign sw_rv[1]        = bus15.rsp_valid;
   assign sw_rb[1]        = bus15.rsp_bit;
   assign sw_rid[1]       = bus15.rsp_id;

   function automatic logic [DW-1:0] rand_data();
      return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   function automatic logic slice_par(input logic [DW-1:0] d, input int id);
      logic [IN_W-1:0] s;
      s = d[id*IN_W +: IN_W];
      return ^s;
   endfunction

   function automatic int exp_grant(input logic [3:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (ptr + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] valid, input logic [DW-1:0] data, input logic ready);
      bus.req_valid = valid;
      bus.req_data  = data;
      bus.rsp_ready = ready;
   endtask

   // Pop the scoreboard whenever a response handshake is about to happen
   always @(negedge clk) begin
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_rsp: got response id %0d, required none", bus.rsp_id);
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput("rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
            checkOutput("rsp_bit", 64'(bus.rsp_bit), 64'(mon_e.bit_v));
            model_served = (model_served == 16'hFFFF) ? 16'hFFFF : model_served + 16'd1;
         end
      end
   end

   // One full transaction: grant, cone load, latency, response, counter
   task automatic runTxn(input logic [3:0] valid, input logic [DW-1:0] data, input int exp_id);
      int lat;
      logic [IN_W-1:0] s;
      applyStimulus(valid, data, 1'b1);
      @(negedge clk);
      checkOutput("grant", 64'(bus.req_ready), 64'(4'b0001 << exp_id));
      s = data[exp_id*IN_W +: IN_W];
      sb_q.push_back('{exp_id, ^s});
      model_ptr = (exp_id + 1) % NREQ;
      @(posedge clk); #1;
      applyStimulus(4'b0000, data, 1'b1);
      checkOutput("cone_in", 64'(bus.cone_in), 64'(s));
      lat = 0;
      while (lat <= 40) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) break;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("latency", 64'(lat), 64'(EVAL_CYC));
      @(posedge clk); #1;
      checkOutput("served_cnt", 64'(bus.served_cnt), 64'(model_served));
   endtask

   // Hold a request pattern and check order and spacing of successive grants
   task automatic rrRun(input logic [3:0] valid, input int ngrants);
      int cyc;
      int last_cyc;
      int ngr;
      int g;
      logic [DW-1:0] d;
      d = rand_data();
      cyc = 0;
      last_cyc = -1;
      ngr = 0;
      applyStimulus(valid, d, 1'b1);
      while (ngr < ngrants && cyc < 80) begin
         @(negedge clk);
         if (bus.req_ready !== 4'b0000) begin
            g = exp_grant(valid, model_ptr);
            checkOutput("rr_order", 64'(bus.req_ready), 64'(4'b0001 << g));
            if (last_cyc >= 0) checkOutput("rr_spacing", 64'(cyc - last_cyc), 64'(EVAL_CYC + 2));
            last_cyc = cyc;
            sb_q.push_back('{g, slice_par(d, g)});
            model_ptr = (g + 1) % NREQ;
            ngr++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput("rr_grant_count", 64'(ngr), 64'(ngrants));
      applyStimulus(4'b0000, d, 1'b1);
      repeat (EVAL_CYC + 2) @(posedge clk);
      #1;
      checkOutput("served_cnt", 64'(bus.served_cnt), 64'(model_served));
   endtask

   // EVAL_CYC sweep instance k: random cone_out each cycle, check capture edge
   task automatic sweepRun(input int k, input int ncyc);
      int lat;
      logic exp_bit;
      sw_valid[k] = 4'b0010;
      sw_ready[k] = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("sweep%0d_grant", ncyc), 64'(sw_rr[k]), 64'(4'b0010));
      @(posedge clk); #1;
      sw_valid[k] = 4'b0000;
      sw_cone[k]  = 1'($urandom_range(0, 1));
      lat = 0;
      exp_bit = 1'b0;
      while (lat <= 40) begin
         @(negedge clk);
         if (sw_rv[k] === 1'b1) break;
         exp_bit = sw_cone[k];
         @(posedge clk); #1;
         lat++;
         sw_cone[k] = 1'($urandom_range(0, 1));
      end
      checkOutput($sformatf("sweep%0d_latency", ncyc), 64'(lat), 64'(ncyc));
      checkOutput($sformatf("sweep%0d_rsp_bit", ncyc), 64'(sw_rb[k]), 64'(exp_bit));
      checkOutput($sformatf("sweep%0d_rsp_id", ncyc), 64'(sw_rid[k]), 64'd1);
      @(posedge clk); #1;
      checkOutput($sformatf("sweep%0d_idle", ncyc), 64'(sw_rv[k]), 64'd0);
   endtask

   initial begin
      logic [DW-1:0] d;
      int lat;
      int g;
      logic exp_bit;

      rst_n        = 1'b0;
      cone_ovr_en  = 1'b0;
      cone_ovr_val = 1'b0;
      model_ptr    = 0;
      model_served = 16'd0;
      for (int k = 0; k < 2; k++) begin
         sw_valid[k] = 4'b0000;
         sw_cone[k]  = 1'b0;
         sw_ready[k] = 1'b0;
      end
      applyStimulus(4'b1111, '0, 1'b0);

      // Reset values, with every requester asking
      repeat (2) @(negedge clk);
      checkOutput("rst_req_ready", 64'(bus.req_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_cone_in", 64'(bus.cone_in), 64'd0);
      checkOutput("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
      checkOutput("rst_rsp_bit", 64'(bus.rsp_bit), 64'd0);
      checkOutput("rst_served", 64'(bus.served_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      applyStimulus(4'b0000, '0, 1'b1);
      @(posedge clk); #1;

      // Requester 0 alone with data 1: parity result is 1
      runTxn(4'b0001, DW'(46'h1), 0);

      // Table of request patterns with hand-derived winners (pointer starts at 1)
      vecs[0] = '{4'b1111, rand_data(), 1};
      vecs[1] = '{4'b0001, rand_data(), 0};
      vecs[2] = '{4'b1000, rand_data(), 3};
      vecs[3] = '{4'b0110, rand_data(), 1};
      vecs[4] = '{4'b0110, rand_data(), 2};
      vecs[5] = '{4'b0011, rand_data(), 0};
      vecs[6] = '{4'b1100, rand_data(), 2};
      vecs[7] = '{4'b1111, rand_data(), 3};
      for (int i = 0; i < 8; i++) begin
         runTxn(vecs[i].valid, vecs[i].data, vecs[i].exp_id);
      end

      // All requesters held: 0,1,2,3,0 four cycles apart
      rrRun(4'b1111, 5);
      // A lone permanently valid requester wins every opportunity
      rrRun(4'b0010, 3);

      // Response held for 10 cycles while cone_out toggles
      d = rand_data();
      applyStimulus(4'b0100, d, 1'b0);
      @(negedge clk);
      g = exp_grant(4'b0100, model_ptr);
      checkOutput("hold_grant", 64'(bus.req_ready), 64'(4'b0001 << g));
      exp_bit = slice_par(d, g);
      sb_q.push_back('{g, exp_bit});
      model_ptr = (g + 1) % NREQ;
      @(posedge clk); #1;
      bus.req_valid = 4'b1111;
      lat = 0;
      while (lat <= 40) begin
         @(negedge clk);
         if (bus.rsp_valid === 1'b1) break;
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("hold_latency", 64'(lat), 64'(EVAL_CYC));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         cone_ovr_en  = 1'b1;
         cone_ovr_val = ~cone_ovr_val;
         @(negedge clk);
         checkOutput("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
         checkOutput("hold_rsp_id", 64'(bus.rsp_id), 64'(g));
         checkOutput("hold_rsp_bit", 64'(bus.rsp_bit), 64'(exp_bit));
         checkOutput("hold_req_ready", 64'(bus.req_ready), 64'd0);
      end
      @(posedge clk); #1;
      cone_ovr_en = 1'b0;
      applyStimulus(4'b0000, d, 1'b1);
      @(posedge clk); #1;
      checkOutput("hold_served", 64'(bus.served_cnt), 64'(model_served));

      // Reset in the middle of requester 2's evaluation
      d = rand_data();
      applyStimulus(4'b0100, d, 1'b1);
      @(negedge clk);
      checkOutput("abort_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_grant(4'b0100, model_ptr)));
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_ptr = 0;
      model_served = 16'd0;
      applyStimulus(4'b0101, d, 1'b1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
         checkOutput("abort_req_ready", 64'(bus.req_ready), 64'd0);
      end
      checkOutput("abort_cone_in", 64'(bus.cone_in), 64'd0);
      checkOutput("abort_served", 64'(bus.served_cnt), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      runTxn(4'b0101, d, 0);
      runTxn(4'b0101, d, 2);

      // Saturation of the served counter
      force dut.served_cnt_q = 16'hFFFE;
      @(posedge clk); #1;
      release dut.served_cnt_q;
      model_served = 16'hFFFE;
      checkOutput("sat_preload", 64'(bus.served_cnt), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         runTxn(4'b1000, rand_data(), 3);
      end
      @(posedge clk); #1;
      checkOutput("sat_hold", 64'(bus.served_cnt), 64'hFFFF);

      // EVAL_CYC extremes
      sweepRun(0, 1);
      sweepRun(1, 15);

      checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_cone_arbiter.md
JPEG_CONE_ARBITER -- requirements
Module: jpeg_cone_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one jpeg timing cone instance.
REQ-002 Parameter IN_W, default 46: cone input vector width.
REQ-003 Parameter EVAL_CYC, default 2, legal range 1..15: multicycle evaluation window of the cone, in clocks.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NREQ  per-requester request strobe.
REQ-007 req_data  input  NREQ*IN_W  per-requester input vector; requester i occupies bits [i*IN_W +: IN_W].
REQ-008 req_ready  output  NREQ  one-hot grant/accept, combinational.
REQ-009 cone_in  output  IN_W  registered vector driving the shared cone.
REQ-010 cone_out  input  1  cone result, valid only after EVAL_CYC cycles of stable cone_in.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_id  output  $clog2(NREQ)  requester index of the response.
REQ-013 rsp_bit  output  1  captured cone result.
REQ-014 rsp_ready  input  1  response consumer accept.
REQ-015 served_cnt  output  16  count of completed responses, saturating.

Function
REQ-016 The FSM SHALL have states IDLE, EVAL and RESP.
REQ-017 In IDLE with any req_valid set, the arbiter SHALL assert req_ready for exactly one requester, chosen round-robin starting at rr_ptr; in any other state req_ready SHALL be all zero.
REQ-018 A handshake (req_valid[i] & req_ready[i]) SHALL, on the same edge, load cone_in from req_data slice i, load rsp_id with i, set rr_ptr to (i+1) mod NREQ, clear the eval counter, and move to EVAL.
REQ-019 cone_in SHALL hold its value from the handshake edge until the next handshake.
REQ-020 EVAL SHALL last exactly EVAL_CYC cycles; on the final EVAL cycle's edge rsp_bit SHALL capture cone_out and the FSM SHALL move to RESP.
REQ-021 rsp_valid SHALL be 1 exactly while in RESP; rsp_id and rsp_bit SHALL be stable while rsp_valid=1 and rsp_ready=0.
REQ-022 Latency: handshake at edge 0 gives rsp_valid=1 in the cycle after edge EVAL_CYC (EVAL_CYC=2: rsp_valid is first high after edge 2).
REQ-023 On rsp_valid & rsp_ready the FSM SHALL return to IDLE and served_cnt SHALL increment, holding at 16'hFFFF once reached.
REQ-024 No new grant SHALL be issued in the cycle of a response handshake; the minimum request-to-request spacing is EVAL_CYC+2 cycles.
REQ-025 A requester dropping req_valid before grant SHALL lose nothing and SHALL NOT move rr_ptr.
REQ-026 With a single requester permanently valid, that requester SHALL be served on every opportunity.
REQ-027 An EVAL_CYC value outside 1..15 SHALL be an elaboration error.

Reset
REQ-028 On rst_n=0, regardless of clk: FSM=IDLE, rr_ptr=0, cone_in=0, rsp_id=0, rsp_bit=0, served_cnt=0, eval counter=0.
REQ-029 While rst_n=0, outputs SHALL read rsp_valid=0 and req_ready=0.
REQ-030 Reset asserted mid-EVAL or mid-RESP SHALL abandon the transaction with no response emitted; the first grant after release SHALL go to requester 0 if it is valid.

Structure
REQ-031 The state enum, the EVAL_CYC legal-range constants and the served_cnt width SHALL live in the shared package jpeg_cone_pkg.
REQ-032 The round-robin pointer logic and the one-hot grant SHALL be one sub-module, rr_arbiter (NREQ parameter; inputs req and ptr; output grant); the remaining logic SHALL be flat.

Verification
REQ-033 Reset, then req_valid=4'b0001 with data 46'h1 and cone model = parity, EVAL_CYC=2 -> req_ready=4'b0001, cone_in=46'h1, rsp_valid first high after edge 2, rsp_id=0, rsp_bit=1.
REQ-034 req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0, each spaced 4 cycles apart.
REQ-035 In RESP, hold rsp_ready=0 for 10 cycles while toggling cone_out -> rsp_bit, rsp_id and rsp_valid all stay constant; req_ready stays 0.
REQ-036 Assert rst_n=0 during EVAL of requester 2 -> no rsp_valid; after release with req_valid=4'b0101, grant goes to 0 and then 2.
REQ-037 Preload served_cnt to 16'hFFFE via 65534 transactions (or force), then complete 3 more -> served_cnt reads FFFF and holds.
REQ-038 Sweep EVAL_CYC=1 and 15 -> rsp_valid first high after edge 1 and edge 15 respectively; rsp_bit equals cone_out sampled on the final EVAL edge.
